alu_arbiter: RTL and testbench

- Shares one combinational ALU between two requesters: requester 0 is the execute stage, requester 1 is the branch/address unit.
- Arbitrates round-robin and latches the winner's operands into an issue register that drives the ALU.
- Waits a fixed settle time, then captures RESULT/SIG_B into a response register and pulses DONE to the winner.
- Sits between the requesters and the ALU instance.

---
 rtl/alu_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of a shared combinational ALU
//
// Purpose:
//   Requester 0 (execute stage) and requester 1 (branch/address unit) share one
//   combinational ALU. A winner is picked in IDLE and its operand fields are latched
//   into the issue register that drives the ALU. After LAT settle cycles the ALU
//   result and branch signal are captured and DONE is pulsed to the winner.
//
// Parameters:
//   DATA_W  operand/result width
//   LAT     ALU settle cycles before capture, legal range 1..4
//
// Optional feature macro:
//   ALU_ARB_FIXED_PRIO_EN  defined: requester 0 always wins a tie (requester 1 may starve)
//                          undefined: round-robin tie break on the last served requester
//
// Ports:
//   i_clk, i_rst                       clock (rising edge), async active-high reset
//   i_req0/1                           request from requester 0/1
//   i_opcode0/1, i_func0/1, i_shamt0/1 instruction fields from each requester
//   i_rs_val0/1, i_rt_val0/1           register operands from each requester
//   i_raw_val0/1                       16-bit immediate from each requester
//   o_gnt0/1                           one-cycle grant pulse, operands latched
//   o_done0/1                          one-cycle completion pulse, result valid
//   o_result_out, o_sig_b_out          captured ALU result / branch signal
//   o_busy                             high whenever the FSM is not IDLE
//   o_alu_*                            issue register driving the ALU inputs
//   i_alu_result, i_alu_sig_b          ALU outputs

`timescale 1ns/1ps

module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [5:0]        i_opcode0,
    input  logic [5:0]        i_opcode1,
    input  logic [5:0]        i_func0,
    input  logic [5:0]        i_func1,
    input  logic [4:0]        i_shamt0,
    input  logic [4:0]        i_shamt1,
    input  logic [DATA_W-1:0] i_rs_val0,
    input  logic [DATA_W-1:0] i_rs_val1,
    input  logic [DATA_W-1:0] i_rt_val0,
    input  logic [DATA_W-1:0] i_rt_val1,
    input  logic [15:0]       i_raw_val0,
    input  logic [15:0]       i_raw_val1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_done0,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_result_out,
    output logic              o_sig_b_out,
    output logic              o_busy,
    output logic [5:0]        o_alu_opcode,
    output logic [5:0]        o_alu_func,
    output logic [4:0]        o_alu_shamt,
    output logic [DATA_W-1:0] o_alu_rs_val,
    output logic [DATA_W-1:0] o_alu_rt_val,
    output logic [15:0]       o_alu_raw_val,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_sig_b
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Settle counter preload; LAT-1 fits in two bits for LAT in 1..4.
    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic        r_win;      // requester currently being served
    logic        w_win;      // requester that would win arbitration this cycle
    logic        w_req_any;
    logic        w_capture;  // last settle cycle: ALU output is stable
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic        r_last;     // last requester served, loses the next tie
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any) w_next = S_EXEC;
            S_EXEC:  if (r_cnt == 2'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output / arbitration decode
    always_comb begin
        o_busy    = (r_state != S_IDLE);
        w_req_any = i_req0 | i_req1;
        w_capture = (r_state == S_EXEC) && (r_cnt == 2'd0);
`ifdef ALU_ARB_FIXED_PRIO_EN
        // Requester 0 wins whenever it asks.
        w_win = ~i_req0;
`else
        // On a tie the requester not served last wins; otherwise the sole requester.
        w_win = (i_req0 & i_req1) ? ~r_last : i_req1;
`endif
    end

    // Issue register, settle counter, pulses and response capture
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_win         <= 1'b0;
            r_cnt         <= 2'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last        <= 1'b1;
`endif
            o_gnt0        <= 1'b0;
            o_gnt1        <= 1'b0;
            o_done0       <= 1'b0;
            o_done1       <= 1'b0;
            o_result_out  <= '0;
            o_sig_b_out   <= 1'b0;
            o_alu_opcode  <= '0;
            o_alu_func    <= '0;
            o_alu_shamt   <= '0;
            o_alu_rs_val  <= '0;
            o_alu_rt_val  <= '0;
            o_alu_raw_val <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Without a request the issue register keeps its last contents.
                    if (w_req_any) begin
                        r_win         <= w_win;
                        r_cnt         <= CNT_INIT;
                        o_gnt0        <= ~w_win;
                        o_gnt1        <= w_win;
                        o_alu_opcode  <= w_win ? i_opcode1  : i_opcode0;
                        o_alu_func    <= w_win ? i_func1    : i_func0;
                        o_alu_shamt   <= w_win ? i_shamt1   : i_shamt0;
                        o_alu_rs_val  <= w_win ? i_rs_val1  : i_rs_val0;
                        o_alu_rt_val  <= w_win ? i_rt_val1  : i_rt_val0;
                        o_alu_raw_val <= w_win ? i_raw_val1 : i_raw_val0;
                    end
                end
                S_EXEC: begin
                    o_gnt0 <= 1'b0;
                    o_gnt1 <= 1'b0;
                    if (w_capture) begin
                        o_result_out <= i_alu_result;
                        o_sig_b_out  <= i_alu_sig_b;
                        o_done0      <= ~r_win;
                        o_done1      <= r_win;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last       <= r_win;
`endif
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    o_done0 <= 1'b0;
                    o_done1 <= 1'b0;
                end
                default: begin
                    o_gnt0  <= 1'b0;
                    o_gnt1  <= 1'b0;
                    o_done0 <= 1'b0;
                    o_done1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter (LAT=1 and LAT=3 instances)

`timescale 1ns/1ps

module tb_alu_arbiter;

    localparam int DW = 32;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0, req1;
    logic [5:0]    op0, op1, fn0, fn1;
    logic [4:0]    sh0, sh1;
    logic [DW-1:0] rs0, rs1, rt0, rt1;
    logic [15:0]   raw0, raw1;

    logic          a_gnt0, a_gnt1, a_done0, a_done1, a_sigb, a_busy;
    logic [DW-1:0] a_result, a_rs, a_rt, a_alu_res;
    logic [5:0]    a_op, a_fn;
    logic [4:0]    a_sh;
    logic [15:0]   a_raw;
    logic          a_alu_sigb;

    logic          b_gnt0, b_gnt1, b_done0, b_done1, b_sigb, b_busy;
    logic [DW-1:0] b_result, b_rs, b_rt, b_alu_res;
    logic [5:0]    b_op, b_fn;
    logic [4:0]    b_sh;
    logic [15:0]   b_raw;
    logic          b_alu_sigb;

    // Reference ALU driven by the issue register of each instance.
    function automatic logic [DW-1:0] alu_f(input logic [5:0] f, input logic [DW-1:0] x, input logic [DW-1:0] y);
        case (f)
            F_ADD:   return x + y;
            F_SUB:   return x - y;
            default: return x ^ y;
        endcase
    endfunction

    assign a_alu_res  = alu_f(a_fn, a_rs, a_rt);
    assign a_alu_sigb = (a_rs == a_rt);
    assign b_alu_res  = alu_f(b_fn, b_rs, b_rt);
    assign b_alu_sigb = (b_rs == b_rt);

    alu_arbiter #(.DATA_W(DW), .LAT(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_req1(req1),
        .i_opcode0(op0), .i_opcode1(op1), .i_func0(fn0), .i_func1(fn1),
        .i_shamt0(sh0), .i_shamt1(sh1), .i_rs_val0(rs0), .i_rs_val1(rs1),
        .i_rt_val0(rt0), .i_rt_val1(rt1), .i_raw_val0(raw0), .i_raw_val1(raw1),
        .o_gnt0(a_gnt0), .o_gnt1(a_gnt1), .o_done0(a_done0), .o_done1(a_done1),
        .o_result_out(a_result), .o_sig_b_out(a_sigb), .o_busy(a_busy),
        .o_alu_opcode(a_op), .o_alu_func(a_fn), .o_alu_shamt(a_sh),
        .o_alu_rs_val(a_rs), .o_alu_rt_val(a_rt), .o_alu_raw_val(a_raw),
        .i_alu_result(a_alu_res), .i_alu_sig_b(a_alu_sigb)
    );

    alu_arbiter #(.DATA_W(DW), .LAT(3)) u_b (
        .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_req1(req1),
        .i_opcode0(op0), .i_opcode1(op1), .i_func0(fn0), .i_func1(fn1),
        .i_shamt0(sh0), .i_shamt1(sh1), .i_rs_val0(rs0), .i_rs_val1(rs1),
        .i_rt_val0(rt0), .i_rt_val1(rt1), .i_raw_val0(raw0), .i_raw_val1(raw1),
        .o_gnt0(b_gnt0), .o_gnt1(b_gnt1), .o_done0(b_done0), .o_done1(b_done1),
        .o_result_out(b_result), .o_sig_b_out(b_sigb), .o_busy(b_busy),
        .o_alu_opcode(b_op), .o_alu_func(b_fn), .o_alu_shamt(b_sh),
        .o_alu_rs_val(b_rs), .o_alu_rt_val(b_rt), .o_alu_raw_val(b_raw),
        .i_alu_result(b_alu_res), .i_alu_sig_b(b_alu_sigb)
    );

    typedef struct { int who; logic [DW-1:0] res; logic sigb; } exp_t;
    typedef struct { int who; logic [DW-1:0] res; logic sigb; int cyc; } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   gnt_q[$];
    bit   both_gnt, both_done;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        gnt_q.delete();
        both_gnt  = 1'b0;
        both_done = 1'b0;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0;
        op0 = 0; op1 = 0; fn0 = 0; fn1 = 0; sh0 = 0; sh1 = 0;
        rs0 = 0; rs1 = 0; rt0 = 0; rt1 = 0; raw0 = 0; raw1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Records grants and DONE events of one instance for n cycles; optionally
    // models a requester dropping REQ once it sees its grant.
    task automatic observe(input bit use_b, input int n, input bit drop);
        logic g0, g1, d0, d1, sb;
        logic [DW-1:0] res;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            g0 = use_b ? b_gnt0 : a_gnt0;   g1 = use_b ? b_gnt1 : a_gnt1;
            d0 = use_b ? b_done0 : a_done0; d1 = use_b ? b_done1 : a_done1;
            res = use_b ? b_result : a_result;
            sb = use_b ? b_sigb : a_sigb;
            if (g0 && g1) both_gnt = 1'b1;
            if (d0 && d1) both_done = 1'b1;
            if (g0) begin gnt_q.push_back(0); if (drop) req0 = 1'b0; end
            if (g1) begin gnt_q.push_back(1); if (drop) req1 = 1'b0; end
            if (d0 || d1) obs_q.push_back('{(d1 ? 1 : 0), res, sb, cyc});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #12;
        checks++; if ({a_gnt0, a_gnt1, a_done0, a_done1, a_busy} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {a_gnt0, a_gnt1, a_done0, a_done1, a_busy}); end
        checks++; if (a_result !== '0 || a_sigb !== 1'b0) begin errors++; $display("FAIL reset_result: got %0h/%b expected 0/0", a_result, a_sigb); end
        checks++; if ({a_op, a_fn, a_sh, a_rs, a_rt, a_raw} !== '0) begin errors++; $display("FAIL reset_issue: got rs=%0h rt=%0h raw=%0h expected 0", a_rs, a_rt, a_raw); end
        checks++; if ({b_busy, b_gnt0, b_gnt1, b_done0, b_done1} !== 5'b0) begin errors++; $display("FAIL reset_lat3: got %b expected 00000", {b_busy, b_gnt0, b_gnt1, b_done0, b_done1}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        clear_sb();
        req0 = 1; op0 = 6'd0; fn0 = F_SUB; sh0 = 5'd17; rs0 = 52; rt0 = 4; raw0 = 16'hBEEF;
        exp_q.push_back('{0, 32'd48, 1'b0});
        @(negedge clk);
        checks++; if ({a_gnt0, a_gnt1} !== 2'b10) begin errors++; $display("FAIL single_gnt: got gnt0/1=%b expected 10", {a_gnt0, a_gnt1}); end
        checks++; if (a_rs !== 32'd52 || a_rt !== 32'd4 || a_fn !== F_SUB) begin errors++; $display("FAIL single_issue: got rs=%0d rt=%0d fn=%b expected 52 4 100010", a_rs, a_rt, a_fn); end
        checks++; if (a_raw !== 16'hBEEF || a_sh !== 5'd17 || a_op !== 6'd0) begin errors++; $display("FAIL single_fields: got raw=%0h sh=%0d op=%0d expected beef 17 0", a_raw, a_sh, a_op); end
        req0 = 0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if ({a_done0, a_done1, a_gnt0} !== 3'b100) begin errors++; $display("FAIL single_done: got done0/done1/gnt0=%b expected 100", {a_done0, a_done1, a_gnt0}); end
        checks++; if (a_result !== e.res || a_sigb !== e.sigb) begin errors++; $display("FAIL single_result: got %0d/%b expected %0d/%b", a_result, a_sigb, e.res, e.sigb); end
        @(negedge clk);
        checks++; if ({a_done0, a_busy, a_gnt1, a_done1} !== 4'b0) begin errors++; $display("FAIL single_after: got %b expected 0000", {a_done0, a_busy, a_gnt1, a_done1}); end
        repeat (2) @(negedge clk);
        checks++; if (a_result !== 32'd48) begin errors++; $display("FAIL single_hold: got %0d expected 48", a_result); end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        obs_t o;
        int   cyc0;
        do_reset();
        clear_sb();
        req0 = 1; fn0 = F_SUB; rs0 = 150; rt0 = 25;
        req1 = 1; fn1 = F_SUB; rs1 = 10;  rt1 = 20;
        exp_q.push_back('{0, 32'd125, 1'b0});
        exp_q.push_back('{1, 32'hFFFF_FFF6, 1'b0});
        observe(1'b0, 8, 1'b1);
        checks++; if (gnt_q.size() != 2) begin errors++; $display("FAIL simul_gnt_count: got %0d expected 2", gnt_q.size()); end
        else begin
            checks++; if (gnt_q[0] != 0 || gnt_q[1] != 1) begin errors++; $display("FAIL simul_gnt_order: got %0d,%0d expected 0,1", gnt_q[0], gnt_q[1]); end
        end
        cyc0 = -1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL simul_done: got no DONE expected requester %0d", e.who); end
            else begin
                o = obs_q.pop_front();
                if (o.who != e.who || o.res !== e.res) begin errors++; $display("FAIL simul_done: got req%0d %0h expected req%0d %0h", o.who, o.res, e.who, e.res); end
                if (cyc0 >= 0) begin
                    checks++; if (o.cyc - cyc0 != 3) begin errors++; $display("FAIL simul_spacing: got %0d expected 3", o.cyc - cyc0); end
                end
                cyc0 = o.cyc;
            end
        end
        checks++; if (both_gnt || both_done) begin errors++; $display("FAIL simul_exclusive: got gnt/done overlap %b%b expected 00", both_gnt, both_done); end
    endtask

    task automatic test_contention();
        exp_t e;
        obs_t o;
        int   want;
        do_reset();
        clear_sb();
        req0 = 1; fn0 = F_ADD; rs0 = 5;   rt0 = 1;
        req1 = 1; fn1 = F_SUB; rs1 = 100; rt1 = 1;
        for (int i = 0; i < 6; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            want = 0;
`else
            want = i % 2;
`endif
            exp_q.push_back('{want, (want == 0) ? 32'd6 : 32'd99, 1'b0});
        end
        observe(1'b0, 18, 1'b0);
        req0 = 0; req1 = 0;
        observe(1'b0, 3, 1'b0);
        checks++; if (gnt_q.size() != 6) begin errors++; $display("FAIL cont_gnt_count: got %0d expected 6", gnt_q.size()); end
        for (int i = 0; i < 6 && i < gnt_q.size(); i++) begin
            checks++; if (gnt_q[i] != exp_q[i].who) begin errors++; $display("FAIL cont_gnt%0d: got %0d expected %0d", i, gnt_q[i], exp_q[i].who); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL cont_done: got no DONE expected requester %0d", e.who); end
            else begin
                o = obs_q.pop_front();
                if (o.who != e.who || o.res !== e.res) begin errors++; $display("FAIL cont_done: got req%0d %0d expected req%0d %0d", o.who, o.res, e.who, e.res); end
            end
        end
        checks++; if (obs_q.size() != 0 || both_gnt || both_done) begin errors++; $display("FAIL cont_extra: got %0d extra DONEs, overlap %b%b expected 0, 00", obs_q.size(), both_gnt, both_done); end
    endtask

    task automatic test_stability();
        exp_t e;
        do_reset();
        clear_sb();
        req0 = 1; fn0 = F_SUB; rs0 = 74; rt0 = 12;
        exp_q.push_back('{0, 32'd62, 1'b0});
        @(negedge clk);
        checks++; if (a_gnt0 !== 1'b1) begin errors++; $display("FAIL stab_gnt: got %b expected 1", a_gnt0); end
        rs0 = 99;
        req0 = 0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (a_rs !== 32'd74) begin errors++; $display("FAIL stab_issue: got %0d expected 74", a_rs); end
        checks++; if (a_done0 !== 1'b1 || a_result !== e.res) begin errors++; $display("FAIL stab_result: got done=%b %0d expected 1 %0d", a_done0, a_result, e.res); end
    endtask

    task automatic test_lat3();
        int busy_n, done_k, gnt_k, done_n;
        logic [DW-1:0] res;
        logic sb;
        do_reset();
        req0 = 1; fn0 = F_SUB; rs0 = 15; rt0 = 15;
        busy_n = 0; done_k = -1; gnt_k = -1; done_n = 0; res = 'x; sb = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (b_busy) busy_n++;
            if (b_gnt0) begin gnt_k = k; req0 = 0; end
            if (b_done0 || b_done1) begin done_n++; done_k = k; res = b_result; sb = b_sigb; end
        end
        checks++; if (gnt_k != 1) begin errors++; $display("FAIL lat3_gnt: got cycle %0d expected 1", gnt_k); end
        checks++; if (done_k != 4 || done_n != 1) begin errors++; $display("FAIL lat3_done: got cycle %0d count %0d expected 4 1", done_k, done_n); end
        checks++; if (busy_n != 4) begin errors++; $display("FAIL lat3_busy: got %0d expected 4", busy_n); end
        checks++; if (res !== 32'd0 || sb !== 1'b1) begin errors++; $display("FAIL lat3_result: got %0h/%b expected 0/1", res, sb); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        do_reset();
        clear_sb();
        req1 = 1; fn1 = F_ADD; rs1 = 20; rt1 = 3;
        observe(1'b1, 6, 1'b1);
        checks++; if (b_result !== 32'd23) begin errors++; $display("FAIL mid_pre: got %0d expected 23", b_result); end
        clear_sb();
        req0 = 1; fn0 = F_SUB; rs0 = 0; rt0 = 7;
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({b_busy, b_gnt0, b_gnt1, b_done0, b_done1} !== 5'b0) begin errors++; $display("FAIL mid_ctrl: got %b expected 00000", {b_busy, b_gnt0, b_gnt1, b_done0, b_done1}); end
        checks++; if (b_result !== '0 || b_rs !== '0) begin errors++; $display("FAIL mid_result: got %0h rs=%0h expected 0 0", b_result, b_rs); end
        @(negedge clk);
        rst = 1'b0;
        observe(1'b1, 6, 1'b0);
        checks++; if (obs_q.size() != 0 || gnt_q.size() != 0) begin errors++; $display("FAIL mid_no_done: got %0d DONE %0d GNT expected 0 0", obs_q.size(), gnt_q.size()); end
        clear_sb();
        req1 = 1; fn1 = F_ADD; rs1 = 3; rt1 = 4;
        exp_q.push_back('{1, 32'd7, 1'b0});
        observe(1'b1, 6, 1'b1);
        checks++;
        if (gnt_q.size() != 1 || obs_q.size() != 1) begin errors++; $display("FAIL mid_next: got %0d GNT %0d DONE expected 1 1", gnt_q.size(), obs_q.size()); end
        else begin
            o = obs_q.pop_front();
            if (gnt_q[0] != 1 || o.who != exp_q[0].who || o.res !== exp_q[0].res) begin errors++; $display("FAIL mid_next: got gnt%0d req%0d %0d expected gnt1 req1 %0d", gnt_q[0], o.who, o.res, exp_q[0].res); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_contention();
        test_stability();
        test_lat3();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
